// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: owner encodings, tag type and kseg0/kseg1 address mapping shared by the SRAM arbiter
package cpu_mem_pkg;
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  typedef struct packed {
    logic valid;
    logic owner;
    logic is_load;
  } tag_t;
  function automatic logic [31:0] kseg_map(input logic [31:0] addr, input logic map_en);
    return (map_en && addr[31:30] == 2'b10) ? {3'b000, addr[28:0]} : addr;
  endfunction
endpackage

// File: rtl/arb_tag_pipe.sv
// arb_tag_pipe: MEM_LAT-deep shift register of in-flight access tags with per-owner pending flags
module arb_tag_pipe
  import cpu_mem_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic resetn,
  input  tag_t tail,
  output tag_t head,
  output logic inst_pend,
  output logic data_pend
);
  tag_t pipe [MEM_LAT];
  always_ff @(posedge clk)
    if (!resetn)
      pipe <= '{default: '0};
    else begin
      pipe[0] <= tail;
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  always_comb begin
    inst_pend = 1'b0;
    data_pend = 1'b0;
    for (int i = 0; i < MEM_LAT - 1; i++) begin
      inst_pend = inst_pend | (pipe[i].valid && pipe[i].owner == OWNER_INST);
      data_pend = data_pend | (pipe[i].valid && pipe[i].owner == OWNER_DATA);
    end
  end
  assign head = pipe[MEM_LAT-1];
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port between fetch and data sides with anti-starvation and kseg mapping
module sram_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4,
  parameter bit MAP_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  output logic        inst_stall,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  logic [3:0]  starve_cnt;
  logic [31:0] inst_rdata_q, data_rdata_q;
  logic        inst_pend, data_pend;
  tag_t        tail, head;
  assign data_gnt    = resetn && data_req && !(inst_req && starve_cnt == 4'(STARVE_MAX));
  assign inst_gnt    = resetn && inst_req && !data_gnt;
  assign mem_en      = inst_gnt | data_gnt;
  assign mem_wen     = data_gnt ? data_wen : 4'b0000;
  assign mem_wdata   = data_gnt ? data_wdata : '0;
  assign mem_addr    = mem_en ? kseg_map(data_gnt ? data_addr : inst_addr, MAP_EN) : '0;
  assign tail        = '{valid: mem_en, owner: data_gnt ? OWNER_DATA : OWNER_INST, is_load: data_gnt && data_wen == 4'b0000};
  assign inst_rvalid = head.valid && head.owner == OWNER_INST;
  assign data_rvalid = head.valid && head.owner == OWNER_DATA;
  assign inst_rdata  = inst_rvalid ? mem_rdata : inst_rdata_q;
  assign data_rdata  = data_rvalid && head.is_load ? mem_rdata : data_rdata_q;
  assign inst_stall  = (inst_req && !inst_gnt) || inst_pend;
  assign data_stall  = (data_req && !data_gnt) || data_pend;
  arb_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
    .clk       (clk),
    .resetn    (resetn),
    .tail      (tail),
    .head      (head),
    .inst_pend (inst_pend),
    .data_pend (data_pend)
  );
  always_ff @(posedge clk)
    if (!resetn) begin
      starve_cnt   <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      starve_cnt <= (inst_req && !inst_gnt) ? starve_cnt + 4'd1 : '0;
      if (inst_rvalid) inst_rdata_q <= mem_rdata;
      if (data_rvalid && head.is_load) data_rdata_q <= mem_rdata;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed vectors with a response scoreboard for MEM_LAT=1 and MEM_LAT=3 arbiters
module tb_sram_port_arbiter;
  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q1[$];
  exp_t q3[$];
  logic        ir = 0, dr = 0, ig, dg, irv, drv, ist, dst, me;
  logic [3:0]  dw = 0, mw;
  logic [31:0] ia = 0, da = 0, dd = 0, ird, drd, ma, mwd, mrd;
  logic        ir3 = 0, dr3 = 0, ig3, dg3, irv3, drv3, ist3, dst3, me3;
  logic [3:0]  dw3 = 0, mw3;
  logic [31:0] ia3 = 0, da3 = 0, dd3 = 0, ird3, drd3, ma3, mwd3, mrd3;
  logic [31:0] a1 = 0;
  logic [31:0] a3 [3] = '{default: 0};
  always #5 clk = ~clk;
  sram_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4), .MAP_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(ir), .inst_addr(ia), .inst_gnt(ig), .inst_rvalid(irv), .inst_rdata(ird), .inst_stall(ist),
    .data_req(dr), .data_wen(dw), .data_addr(da), .data_wdata(dd), .data_gnt(dg), .data_rvalid(drv),
    .data_rdata(drd), .data_stall(dst),
    .mem_en(me), .mem_wen(mw), .mem_addr(ma), .mem_wdata(mwd), .mem_rdata(mrd)
  );
  sram_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4), .MAP_EN(1'b1)) dut3 (
    .clk(clk), .resetn(resetn),
    .inst_req(ir3), .inst_addr(ia3), .inst_gnt(ig3), .inst_rvalid(irv3), .inst_rdata(ird3), .inst_stall(ist3),
    .data_req(dr3), .data_wen(dw3), .data_addr(da3), .data_wdata(dd3), .data_gnt(dg3), .data_rvalid(drv3),
    .data_rdata(drd3), .data_stall(dst3),
    .mem_en(me3), .mem_wen(mw3), .mem_addr(ma3), .mem_wdata(mwd3), .mem_rdata(mrd3)
  );
  always @(posedge clk) begin
    a1 <= me ? ma : '0;
    a3[0] <= me3 ? ma3 : '0;
    a3[1] <= a3[0];
    a3[2] <= a3[1];
  end
  assign mrd  = ~a1;
  assign mrd3 = ~a3[2];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive1(input logic i_r, input logic [31:0] i_a, input logic d_r, input logic [3:0] d_w,
                        input logic [31:0] d_a, input logic [31:0] d_d);
    @(posedge clk);
    #1;
    ir = i_r; ia = i_a; dr = d_r; dw = d_w; da = d_a; dd = d_d;
    @(negedge clk);
  endtask
  task automatic drive3(input logic i_r, input logic [31:0] i_a, input logic d_r, input logic [3:0] d_w,
                        input logic [31:0] d_a, input logic [31:0] d_d);
    @(posedge clk);
    #1;
    ir3 = i_r; ia3 = i_a; dr3 = d_r; dw3 = d_w; da3 = d_a; dd3 = d_d;
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (irv || drv) begin
      if (q1.size() == 0) chk("rsp1_unexpected", 32'({irv, drv}), 32'd0);
      else begin
        e = q1.pop_front();
        chk("rsp1_owner", 32'({irv, drv}), e.owner ? 32'd1 : 32'd2);
        chk("rsp1_rdata", e.owner ? drd : ird, e.rdata);
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (irv3 || drv3) begin
      if (q3.size() == 0) chk("rsp3_unexpected", 32'({irv3, drv3}), 32'd0);
      else begin
        e = q3.pop_front();
        chk("rsp3_owner", 32'({irv3, drv3}), e.owner ? 32'd1 : 32'd2);
        chk("rsp3_rdata", e.owner ? drd3 : ird3, e.rdata);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("reset_ctl", 32'({ig, dg, irv, drv, ist, dst, me, mw}), 32'd0);
    chk("reset_addr", ma, 32'd0);
    chk("reset_rdata", ird | drd, 32'd0);
    drive1(1, 32'hBFC0_0000, 0, 4'b0000, 32'd0, 32'd0);
    chk("t1_gnt", 32'({ig, dg}), 32'd2);
    chk("t1_addr", ma, 32'h1FC0_0000);
    chk("t1_wen_wdata", 32'({mw, mwd[27:0]}), 32'd0);
    chk("t1_stall", 32'({ist, dst}), 32'd0);
    q1.push_back('{1'b0, 32'hE03F_FFFF});
    drive1(0, 32'd0, 0, 4'b0000, 32'd0, 32'd0);
    drive1(0, 32'd0, 0, 4'b0000, 32'd0, 32'd0);
    chk("t1_hold", ird, 32'hE03F_FFFF);
    chk("t1_no_rvalid", 32'({irv, drv}), 32'd0);
    drive1(1, 32'hBFC0_0004, 1, 4'b0000, 32'h8000_0010, 32'd0);
    chk("t2_gnt", 32'({ig, dg}), 32'd1);
    chk("t2_stall", 32'({ist, dst}), 32'd2);
    chk("t2_addr", ma, 32'h0000_0010);
    q1.push_back('{1'b1, 32'hFFFF_FFEF});
    drive1(1, 32'hBFC0_0004, 0, 4'b0000, 32'd0, 32'd0);
    chk("t2_inst_next", 32'({ig, dg, ist}), 32'd4);
    chk("t2_addr_next", ma, 32'h1FC0_0004);
    q1.push_back('{1'b0, 32'hE03F_FFFB});
    drive1(0, 32'd0, 0, 4'b0000, 32'd0, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      drive1(1, 32'hBFC0_0008, 1, 4'b0000, 32'h8000_0020, 32'd0);
      if (k < 5) begin
        chk("t3_data_wins", 32'({ig, dg}), 32'd1);
        q1.push_back('{1'b1, 32'hFFFF_FFDF});
      end else begin
        chk("t3_override_gnt", 32'({ig, dg}), 32'd2);
        chk("t3_override_dstall", 32'(dst), 32'd1);
        chk("t3_override_addr", ma, 32'h1FC0_0008);
        q1.push_back('{1'b0, 32'hE03F_FFF7});
      end
    end
    drive1(1, 32'hBFC0_0008, 1, 4'b0000, 32'h8000_0020, 32'd0);
    chk("t3_data_retry", 32'({ig, dg}), 32'd1);
    q1.push_back('{1'b1, 32'hFFFF_FFDF});
    drive1(0, 32'd0, 1, 4'b0011, 32'h8000_0040, 32'h1234_5678);
    chk("t4_gnt", 32'({ig, dg}), 32'd1);
    chk("t4_wen", 32'(mw), 32'd3);
    chk("t4_wdata", mwd, 32'h1234_5678);
    chk("t4_addr", ma, 32'h0000_0040);
    q1.push_back('{1'b1, 32'hFFFF_FFDF});
    drive1(0, 32'd0, 0, 4'b0000, 32'd0, 32'd0);
    drive1(0, 32'd0, 0, 4'b0000, 32'd0, 32'd0);
    chk("t4_rdata_held", drd, 32'hFFFF_FFDF);
    drive1(1, 32'hC000_1000, 0, 4'b0000, 32'd0, 32'd0);
    chk("map_kseg2_pass", ma, 32'hC000_1000);
    q1.push_back('{1'b0, 32'h3FFF_EFFF});
    drive1(1, 32'hBFAF_0000, 0, 4'b0000, 32'd0, 32'd0);
    chk("map_kseg1", ma, 32'h1FAF_0000);
    q1.push_back('{1'b0, 32'hE050_FFFF});
    drive1(0, 32'd0, 1, 4'b0000, 32'h8000_1000, 32'd0);
    chk("map_kseg0", ma, 32'h0000_1000);
    q1.push_back('{1'b1, 32'hFFFF_EFFF});
    drive1(1, 32'h0000_2000, 0, 4'b0000, 32'd0, 32'd0);
    chk("map_kuseg_pass", ma, 32'h0000_2000);
    q1.push_back('{1'b0, 32'hFFFF_DFFF});
    drive1(0, 32'd0, 0, 4'b0000, 32'd0, 32'd0);
    drive1(0, 32'd0, 0, 4'b0000, 32'd0, 32'd0);
    drive3(0, 32'd0, 1, 4'b0000, 32'h8000_0100, 32'd0);
    chk("t5_d1_gnt", 32'({ig3, dg3, ist3, dst3}), 32'b0100);
    q3.push_back('{1'b1, 32'hFFFF_FEFF});
    drive3(1, 32'hBFC0_0100, 0, 4'b0000, 32'd0, 32'd0);
    chk("t5_i_gnt", 32'({ig3, dg3, ist3, dst3}), 32'b1001);
    q3.push_back('{1'b0, 32'hE03F_FEFF});
    drive3(0, 32'd0, 1, 4'b0000, 32'h8000_0200, 32'd0);
    chk("t5_d2_gnt", 32'({ig3, dg3, ist3, dst3}), 32'b0111);
    q3.push_back('{1'b1, 32'hFFFF_FDFF});
    repeat (4) drive3(0, 32'd0, 0, 4'b0000, 32'd0, 32'd0);
    chk("t5_held", ird3, 32'hE03F_FEFF);
    drive3(1, 32'hBFC0_0200, 0, 4'b0000, 32'd0, 32'd0);
    chk("t6_i_gnt", 32'({ig3, dg3}), 32'd2);
    drive3(0, 32'd0, 1, 4'b0000, 32'h8000_0300, 32'd0);
    chk("t6_d_gnt", 32'({ig3, dg3}), 32'd1);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    dr3 = 1'b0;
    da3 = '0;
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6_ctl_zero", 32'({ig3, dg3, irv3, drv3, ist3, dst3, me3, mw3}), 32'd0);
      chk("t6_rdata_zero", ird3 | drd3, 32'd0);
      chk("t6_bus_zero", ma3 | mwd3, 32'd0);
      @(posedge clk);
    end
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
